bf_sweep_ctrl: RTL and testbench

//   Sequencer for the 3-input / 2-output Boolean-function datapath (A,B,C -> D,E).
//   On a start request it drives all 8 input vectors in binary order, waits a programmable settle time per vector,
//   and captures D and E into 8-bit truth-table registers. It replaces hand-timed testbench stimulus and sits

---
 rtl/bf_sweep_ctrl_pkg.sv | 14 +
 rtl/bf_dwell_timer.sv | 27 ++
 rtl/bf_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_bf_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_sweep_ctrl_pkg.sv
// Shared state encoding and sweep constants for the Boolean-function sweep sequencer.
package bf_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int         BF_N_VEC    = 8;
  localparam logic [2:0] BF_VEC_LAST = 3'd7;

endpackage

// File: rtl/bf_dwell_timer.sv
// Loadable down-counter timing the settle phase; expire is high while the count is zero.
module bf_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/bf_sweep_ctrl.sv
// Sweeps all 8 {a,b,c} vectors through a 3-in/2-out datapath and captures d/e truth tables.
// Optional self-check against expected tables is enabled by defining BF_SWEEP_CHECK_EN.
module bf_sweep_ctrl
  import bf_sweep_ctrl_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  input  logic               d,
  input  logic               e,
  output logic               busy,
  output logic               done,
  output logic [7:0]         res_d,
  output logic [7:0]         res_e
`ifdef BF_SWEEP_CHECK_EN
  ,
  input  logic [7:0]         exp_d,
  input  logic [7:0]         exp_e,
  output logic               pass
`endif
);

  state_t             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [DWELL_W-1:0] dwell_m1_q;
  logic [DWELL_W-1:0] dwell_m1;
  logic [7:0]         res_d_q, res_e_q;
  logic               tmr_load, tmr_en, tmr_expire;
  logic [DWELL_W-1:0] tmr_val;
  logic               cap, clr;

  // Timer is loaded with D-1 so SETTLE lasts exactly D cycles; dwell of 0 behaves as 1.
  assign dwell_m1 = dwell - DWELL_W'(dwell != '0);

  bf_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .value  (tmr_val),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= 3'd0;
      dwell_m1_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      if (clr) dwell_m1_q <= dwell_m1;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = dwell_m1_q;
    cap      = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_SETTLE;
          vec_d    = 3'd0;
          tmr_load = 1'b1;
          tmr_val  = dwell_m1;
          clr      = 1'b1;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = 3'd0;
        end else if (tmr_expire) begin
          state_d = S_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = 3'd0;
        end else begin
          cap = 1'b1;
          if (vec_q == BF_VEC_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SETTLE;
            vec_d    = vec_q + 3'd1;
            tmr_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_d_q <= 8'h00;
      res_e_q <= 8'h00;
    end else if (clr) begin
      res_d_q <= 8'h00;
      res_e_q <= 8'h00;
    end else if (cap) begin
      res_d_q[vec_q] <= d;
      res_e_q[vec_q] <= e;
    end
  end

  assign busy        = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done        = (state_q == S_DONE);
  assign {a, b, c}   = busy ? vec_q : 3'd0;
  assign res_d       = res_d_q;
  assign res_e       = res_e_q;

`ifdef BF_SWEEP_CHECK_EN
  logic [7:0] exp_d_q, exp_e_q;
  logic       pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_d_q <= 8'h00;
      exp_e_q <= 8'h00;
      pass_q  <= 1'b0;
    end else if (clr) begin
      exp_d_q <= exp_d;
      exp_e_q <= exp_e;
      pass_q  <= 1'b0;
    end else if (state_q == S_DONE) begin
      pass_q <= (res_d_q == exp_d_q) && (res_e_q == exp_e_q);
    end
  end

  assign pass = pass_q;
`endif

endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// Directed bench for bf_sweep_ctrl with an XOR/majority stub datapath.
module tb_bf_sweep_ctrl;

  logic       clk, rst, start, abort;
  logic [7:0] dwell;
  logic       a, b, c, d, e, busy, done;
  logic [7:0] res_d, res_e;
`ifdef BF_SWEEP_CHECK_EN
  logic [7:0] exp_d, exp_e;
  logic       pass;
`endif

  int total = 0;
  int bad   = 0;

  assign d = a ^ b ^ c;
  assign e = (a & b) | (a & c) | (b & c);

  bf_sweep_ctrl #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .dwell (dwell),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .busy  (busy),
    .done  (done),
    .res_d (res_d),
    .res_e (res_e)
`ifdef BF_SWEEP_CHECK_EN
    ,
    .exp_d (exp_d),
    .exp_e (exp_e),
    .pass  (pass)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge after the edge that accepted start (n = 0).
  task automatic start_pulse(input logic [7:0] dw);
    @(negedge clk);
    dwell = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, c} !== 3'b000 || res_d !== 8'h00 || res_e !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b abc=%b res_d=%h res_e=%h need all zero",
               busy, done, {a, b, c}, res_d, res_e);
    end
`ifdef BF_SWEEP_CHECK_EN
    total++;
    if (pass !== 1'b0) begin
      bad++;
      $display("FAIL reset_pass got %b need 0", pass);
    end
`endif
    $display("reset: busy=%b done=%b abc=%b", busy, done, {a, b, c});
  endtask

  task automatic test_sweep(input logic [7:0] dw);
    int         dd;
    int         n;
    logic [2:0] expv;
    dd = (dw == 8'd0) ? 1 : int'(dw);
    start_pulse(dw);
    n = 0;
    while (!done && n < 200) begin
      expv = 3'(n / (dd + 1));
      total++;
      if (busy !== 1'b1 || {a, b, c} !== expv) begin
        bad++;
        $display("FAIL sweep_step dw=%0d n=%0d got busy=%b abc=%b need busy=1 abc=%b",
                 dw, n, busy, {a, b, c}, expv);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 8 * (dd + 1)) begin
      bad++;
      $display("FAIL done_latency dw=%0d got %0d need %0d", dw, n, 8 * (dd + 1));
    end
    total++;
    if (busy !== 1'b0 || {a, b, c} !== 3'b000 || res_d !== 8'h96 || res_e !== 8'hE8) begin
      bad++;
      $display("FAIL sweep_result dw=%0d got busy=%b abc=%b res_d=%h res_e=%h need 0 000 96 e8",
               dw, busy, {a, b, c}, res_d, res_e);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || res_d !== 8'h96 || res_e !== 8'hE8) begin
      bad++;
      $display("FAIL done_pulse_hold dw=%0d got done=%b res_d=%h res_e=%h need 0 96 e8",
               dw, done, res_d, res_e);
    end
    $display("sweep dw=%0d done_at=%0d res_d=%h res_e=%h", dw, n, res_d, res_e);
  endtask

  task automatic test_abort();
    int seen_done;
    start_pulse(8'd4);
    repeat (16) @(negedge clk);
    total++;
    if (busy !== 1'b1 || {a, b, c} !== 3'b011) begin
      bad++;
      $display("FAIL abort_pre got busy=%b abc=%b need 1 011", busy, {a, b, c});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, c} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle got busy=%b done=%b abc=%b need 0 0 000", busy, done, {a, b, c});
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
      @(negedge clk);
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL abort_no_done got activity=%0d need 0", seen_done);
    end
    total++;
    if (res_d !== 8'h06 || res_e !== 8'h00) begin
      bad++;
      $display("FAIL abort_partial got res_d=%h res_e=%h need 06 00", res_d, res_e);
    end
    $display("abort: res_d=%h res_e=%h", res_d, res_e);
  endtask

  task automatic test_start_ignored();
    int n;
    start_pulse(8'd2);
    n = 0;
    while (!done && n < 200) begin
      start = (n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total++;
    if (n !== 24 || res_d !== 8'h96 || res_e !== 8'hE8) begin
      bad++;
      $display("FAIL start_mid_sweep got done_at=%0d res_d=%h res_e=%h need 24 96 e8", n, res_d, res_e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done got busy=%b done=%b need 0 0", busy, done);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || {a, b, c} !== 3'b000) begin
      bad++;
      $display("FAIL start_abort_idle got busy=%b abc=%b need 0 000", busy, {a, b, c});
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || res_d !== 8'h96) begin
      bad++;
      $display("FAIL start_abort_hold got busy=%b res_d=%h need 0 96", busy, res_d);
    end
    $display("start_ignored: done_at=%0d busy=%b", n, busy);
  endtask

  task automatic test_async_reset();
    start_pulse(8'd2);
    repeat (17) @(negedge clk);
    total++;
    if (busy !== 1'b1 || {a, b, c} !== 3'b101) begin
      bad++;
      $display("FAIL rst_pre got busy=%b abc=%b need 1 101", busy, {a, b, c});
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, c} !== 3'b000 || res_d !== 8'h00 || res_e !== 8'h00) begin
      bad++;
      $display("FAIL rst_async got busy=%b done=%b abc=%b res_d=%h res_e=%h need all zero",
               busy, done, {a, b, c}, res_d, res_e);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("async_reset: busy=%b res_d=%h", busy, res_d);
  endtask

`ifdef BF_SWEEP_CHECK_EN
  task automatic test_check(input logic [7:0] ed, input logic [7:0] ee, input logic want);
    int n;
    exp_d = ed;
    exp_e = ee;
    start_pulse(8'd1);
    total++;
    if (pass !== 1'b0) begin
      bad++;
      $display("FAIL pass_cleared got %b need 0", pass);
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (n !== 16 || pass !== want) begin
      bad++;
      $display("FAIL pass_result exp_e=%h got done_at=%0d pass=%b need 16 %b", ee, n, pass, want);
    end
    $display("check: exp_d=%h exp_e=%h pass=%b", ed, ee, pass);
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dwell = 8'd0;
`ifdef BF_SWEEP_CHECK_EN
    exp_d = 8'h00;
    exp_e = 8'h00;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_sweep(8'd2);
    test_sweep(8'd0);
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_sweep(8'd2);
`ifdef BF_SWEEP_CHECK_EN
    test_check(8'h96, 8'hE8, 1'b1);
    test_check(8'h96, 8'hE9, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
